// File: rtl/gate_input_debouncer_pkg.sv
// Shared defaults and types for the two-channel gate input debouncer.
// The testbench imports the same constants to derive expected latency.
package gate_input_debouncer_pkg;

    localparam int GATE_STABLE_CYCLES = 4;
    localparam int GATE_CNT_W         = 4;

    // Raw edge to debounced level: two synchroniser edges plus the stability window.
    localparam int GATE_LATENCY = 2 + GATE_STABLE_CYCLES;

    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } ch_out_t;

endpackage

// File: rtl/gate_input_debouncer_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean
// level register and registered rise/fall pulses aligned with the level.
module debounce_ch
    import gate_input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = GATE_STABLE_CYCLES,
    parameter int CNT_W         = GATE_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_q1;
    logic             r_q2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;

    logic             w_out_next;
    logic [CNT_W-1:0] w_cnt_next;

    // Any return of q2 to the current level clears the count: no partial credit.
    always_comb begin
        w_out_next = r_out;
        w_cnt_next = '0;
        if (r_q2 != r_out) begin
            if (r_cnt == CNT_LAST) begin
                w_out_next = r_q2;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1   <= 1'b0;
            r_q2   <= 1'b0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_q1   <= i_raw;
            r_q2   <= r_q1;
            r_cnt  <= w_cnt_next;
            r_out  <= w_out_next;
            r_rise <= w_out_next & ~r_out;
            r_fall <= ~w_out_next & r_out;
        end
    end

    assign o_lvl  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/gate_input_debouncer.sv
// Two independent debounce channels conditioning raw pins for the or_gate.
module gate_input_debouncer
    import gate_input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = GATE_STABLE_CYCLES,
    parameter int CNT_W         = GATE_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (a_raw),
        .o_lvl  (a),
        .o_rise (a_rise),
        .o_fall (a_fall)
    );

    debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (b_raw),
        .o_lvl  (b),
        .o_rise (b_rise),
        .o_fall (b_fall)
    );

endmodule
